control_unit: RTL

- Hardwired control unit for the 12-bit-address / 16-bit-word basic computer.
- Sits directly upstream of the datapath and drives every register RESET/INC/WRITE strobe, the bus select, memory read/write and ALU operation.
- Runs a T0..T6 timing sequence for fetch, decode, indirect and execute of memory-reference and register-reference instructions.
- Control outputs are decoded from registered state (SC, I flag, HALTED) plus the live IR_IN, AC_IN, DR_ZERO and E_IN inputs.

---
 rtl/control_pkg.sv | 69 ++++++
 rtl/control_unit_seq_counter.sv | 19 +
 rtl/control_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the basic-computer control unit: bus sources, ALU
// operations, opcodes, register-reference bit positions and T-states.
package control_pkg;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_AR   = 3'd1,
        BUS_PC   = 3'd2,
        BUS_DR   = 3'd3,
        BUS_AC   = 3'd4,
        BUS_IR   = 3'd5,
        BUS_TR   = 3'd6,
        BUS_MEM  = 3'd7
    } bus_sel_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_ADD = 3'd1,
        ALU_DR  = 3'd2,
        ALU_CMA = 3'd3,
        ALU_CIR = 3'd4,
        ALU_CIL = 3'd5
    } alu_sel_t;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6,
        T_ILLEGAL = 3'd7
    } t_state_t;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_LDA    = 3'd2;
    localparam logic [2:0] OP_STA    = 3'd3;
    localparam logic [2:0] OP_BUN    = 3'd4;
    localparam logic [2:0] OP_BSA    = 3'd5;
    localparam logic [2:0] OP_ISZ    = 3'd6;
    localparam logic [2:0] OP_REGREF = 3'd7;

    localparam logic [3:0] RR_CLA = 4'd11;
    localparam logic [3:0] RR_CLE = 4'd10;
    localparam logic [3:0] RR_CMA = 4'd9;
    localparam logic [3:0] RR_CME = 4'd8;
    localparam logic [3:0] RR_CIR = 4'd7;
    localparam logic [3:0] RR_CIL = 4'd6;
    localparam logic [3:0] RR_INC = 4'd5;
    localparam logic [3:0] RR_SPA = 4'd4;
    localparam logic [3:0] RR_SNA = 4'd3;
    localparam logic [3:0] RR_SZA = 4'd2;
    localparam logic [3:0] RR_SZE = 4'd1;
    localparam logic [3:0] RR_HLT = 4'd0;
    localparam logic [3:0] RR_NONE = 4'd15;

    // Index of the most significant set bit; RR_NONE when no bit is set.
    function automatic logic [3:0] rr_highest(input logic [11:0] bits);
        logic [3:0] idx;
        idx = RR_NONE;
        for (int k = 0; k < 12; k++) begin
            if (bits[k]) idx = 4'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/control_unit_seq_counter.sv
// Sequence counter: synchronous clear has priority over increment; otherwise holds.
module seq_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: T0..T6 sequencing of fetch, decode, indirect and
// execute, decoding every datapath strobe from SC, I, D, HALTED and live inputs.
module control_unit
    import control_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SC_W   = 3
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] IR_IN,
    input  logic [DATA_W-1:0] AC_IN,
    input  logic              DR_ZERO,
    input  logic              E_IN,
    output logic              AR_RESET,
    output logic              AR_INC,
    output logic              AR_WRITE,
    output logic              PC_RESET,
    output logic              PC_INC,
    output logic              PC_WRITE,
    output logic              DR_RESET,
    output logic              DR_INC,
    output logic              DR_WRITE,
    output logic              AC_RESET,
    output logic              AC_INC,
    output logic              AC_WRITE,
    output logic              IR_RESET,
    output logic              IR_INC,
    output logic              IR_WRITE,
    output logic              TR_RESET,
    output logic              TR_INC,
    output logic              TR_WRITE,
    output logic [2:0]        BUS_SEL,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [2:0]        ALU_SEL,
    output logic              E_LOAD,
    output logic              E_CLR,
    output logic              E_CMP,
    output logic [SC_W-1:0]   SC_OUT,
    output logic              HALTED
);

    logic [SC_W-1:0] sc;
    logic            sc_clr;
    logic            sc_inc;
    logic            i_reg, i_next;
    logic [2:0]      d_reg, d_next;
    logic            halted_reg, halted_next;
    logic [3:0]      rr_idx;
    t_state_t        t_state;

    seq_counter #(.W(SC_W)) u_seq_counter (
        .clk   (CLK),
        .clr   (sc_clr),
        .inc   (sc_inc),
        .count (sc)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            i_reg      <= 1'b0;
            d_reg      <= 3'd0;
            halted_reg <= 1'b0;
        end else begin
            i_reg      <= i_next;
            d_reg      <= d_next;
            halted_reg <= halted_next;
        end
    end

    assign t_state = t_state_t'(sc[2:0]);

    always_comb begin
        AR_RESET = 1'b0; AR_INC = 1'b0; AR_WRITE = 1'b0;
        PC_RESET = 1'b0; PC_INC = 1'b0; PC_WRITE = 1'b0;
        DR_RESET = 1'b0; DR_INC = 1'b0; DR_WRITE = 1'b0;
        AC_RESET = 1'b0; AC_INC = 1'b0; AC_WRITE = 1'b0;
        IR_RESET = 1'b0; IR_INC = 1'b0; IR_WRITE = 1'b0;
        TR_RESET = 1'b0; TR_INC = 1'b0; TR_WRITE = 1'b0;
        BUS_SEL   = BUS_NONE;
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        ALU_SEL   = ALU_AND;
        E_LOAD    = 1'b0;
        E_CLR     = 1'b0;
        E_CMP     = 1'b0;
        SC_OUT    = '0;
        HALTED    = 1'b0;
        sc_clr      = 1'b0;
        sc_inc      = 1'b1;
        i_next      = i_reg;
        d_next      = d_reg;
        halted_next = halted_reg;
        rr_idx      = rr_highest(IR_IN[11:0]);

        if (!RESET_N) begin
            // Reset wins over any in-flight T-state: only the *_RESET strobes go out.
            AR_RESET = 1'b1; PC_RESET = 1'b1; DR_RESET = 1'b1;
            AC_RESET = 1'b1; IR_RESET = 1'b1; TR_RESET = 1'b1;
            sc_clr   = 1'b1;
        end else if (halted_reg) begin
            HALTED = 1'b1;
            sc_clr = 1'b1;
        end else begin
            SC_OUT = sc;
            unique case (t_state)
                T0: begin
                    BUS_SEL  = BUS_PC;
                    AR_WRITE = 1'b1;
                end
                T1: begin
                    BUS_SEL  = BUS_MEM;
                    MEM_READ = 1'b1;
                    IR_WRITE = 1'b1;
                    PC_INC   = 1'b1;
                end
                T2: begin
                    BUS_SEL  = BUS_IR;
                    AR_WRITE = 1'b1;
                    i_next   = IR_IN[DATA_W-1];
                    d_next   = IR_IN[14:12];
                end
                T3: begin
                    if (d_reg == OP_REGREF) begin
                        sc_clr = 1'b1;
                        // I=1 with D=7 is the I/O group, treated as a NOP.
                        if (!i_reg) begin
                            case (rr_idx)
                                RR_CLA: AC_RESET = 1'b1;
                                RR_CLE: E_CLR = 1'b1;
                                RR_CMA: begin ALU_SEL = ALU_CMA; AC_WRITE = 1'b1; end
                                RR_CME: E_CMP = 1'b1;
                                RR_CIR: begin ALU_SEL = ALU_CIR; AC_WRITE = 1'b1; E_LOAD = 1'b1; end
                                RR_CIL: begin ALU_SEL = ALU_CIL; AC_WRITE = 1'b1; E_LOAD = 1'b1; end
                                RR_INC: AC_INC = 1'b1;
                                RR_SPA: PC_INC = ~AC_IN[DATA_W-1];
                                RR_SNA: PC_INC = AC_IN[DATA_W-1];
                                RR_SZA: PC_INC = (AC_IN == '0);
                                RR_SZE: PC_INC = ~E_IN;
                                RR_HLT: halted_next = 1'b1;
                                default: ;
                            endcase
                        end
                    end else if (i_reg) begin
                        BUS_SEL  = BUS_MEM;
                        MEM_READ = 1'b1;
                        AR_WRITE = 1'b1;
                    end
                end
                T4: begin
                    case (d_reg)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            BUS_SEL  = BUS_MEM;
                            MEM_READ = 1'b1;
                            DR_WRITE = 1'b1;
                        end
                        OP_STA: begin
                            BUS_SEL   = BUS_AC;
                            MEM_WRITE = 1'b1;
                            sc_clr    = 1'b1;
                        end
                        OP_BUN: begin
                            BUS_SEL  = BUS_AR;
                            PC_WRITE = 1'b1;
                            sc_clr   = 1'b1;
                        end
                        OP_BSA: begin
                            BUS_SEL   = BUS_PC;
                            MEM_WRITE = 1'b1;
                            AR_INC    = 1'b1;
                        end
                        default: sc_clr = 1'b1;
                    endcase
                end
                T5: begin
                    case (d_reg)
                        OP_AND, OP_ADD, OP_LDA: begin
                            ALU_SEL  = (d_reg == OP_AND) ? ALU_AND :
                                       (d_reg == OP_ADD) ? ALU_ADD : ALU_DR;
                            AC_WRITE = 1'b1;
                            E_LOAD   = (d_reg == OP_ADD);
                            sc_clr   = 1'b1;
                        end
                        OP_BSA: begin
                            BUS_SEL  = BUS_AR;
                            PC_WRITE = 1'b1;
                            sc_clr   = 1'b1;
                        end
                        OP_ISZ: DR_INC = 1'b1;
                        default: sc_clr = 1'b1;
                    endcase
                end
                T6: begin
                    sc_clr = 1'b1;
                    // DR_ZERO here reflects the value incremented during T5.
                    if (d_reg == OP_ISZ) begin
                        BUS_SEL   = BUS_DR;
                        MEM_WRITE = 1'b1;
                        PC_INC    = DR_ZERO;
                    end
                end
                default: sc_clr = 1'b1;
            endcase
        end
    end

endmodule
